// File: rtl/mvm64_tile_sched.sv
// Sequences the 16 tiles of a 64x64 matrix-vector product, accumulating lanes per output segment.
// Minimum latency 33 cycles from the start edge to result_valid; start while busy is dropped.
module mvm64_tile_sched #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                tile_start,
    output logic [1:0]          tile_row,
    output logic [1:0]          tile_col,
    input  logic                tile_done,
    input  logic [16*DW-1:0]    tile_psum,
    output logic [64*DW-1:0]    result,
    output logic                result_valid,
    output logic                err
);

    localparam int SEGW = 16 * DW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         r_q, r_d;
    logic [1:0]         k_q, k_d;
    logic [SEGW-1:0]    acc_q, acc_d;
    logic [64*DW-1:0]   stage_q, stage_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [64*DW-1:0]   result_q, result_d;
    logic               rv_q, rv_d;
    logic               err_q, err_d;

    logic [SEGW-1:0]    lane_sum;
    logic [15:0]        cnt_inc;

    // Lane-wise wrap-around add; each lane's carry-out is simply dropped.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 16; i++) begin
            lane_sum[i*DW +: DW] = acc_q[i*DW +: DW] + tile_psum[i*DW +: DW];
        end
    end

    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        k_d      = k_q;
        acc_d    = acc_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rv_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r_d     = 2'd0;
                    k_d     = 2'd0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (tile_done) begin
                    if (k_q != 2'd3) begin
                        acc_d   = lane_sum;
                        k_d     = k_q + 2'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        for (int s = 0; s < 4; s++) begin
                            if (r_q == 2'(3 - s)) begin
                                stage_d[s*SEGW +: SEGW] = lane_sum;
                            end
                        end
                        acc_d = '0;
                        k_d   = 2'd0;
                        if (r_q != 2'd3) begin
                            r_d     = r_q + 2'd1;
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 16'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        r_d     = 2'd0;
                        k_d     = 2'd0;
                        acc_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                result_d = stage_q;
                rv_d     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r_q      <= 2'd0;
            k_q      <= 2'd0;
            acc_q    <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign tile_start   = (state_q == ST_ISSUE);
    assign tile_row     = r_q;
    assign tile_col     = k_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mvm64_tile_sched.sv
// Bench for mvm64_tile_sched: behavioural tile engine plus a result scoreboard.
module tb_mvm64_tile_sched;

    localparam int DW = 16;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               tile_start;
    logic [1:0]         tile_row;
    logic [1:0]         tile_col;
    logic               tile_done;
    logic [16*DW-1:0]   tile_psum;
    logic [64*DW-1:0]   result;
    logic               result_valid;
    logic               err;

    mvm64_tile_sched #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .tile_start   (tile_start),
        .tile_row     (tile_row),
        .tile_col     (tile_col),
        .tile_done    (tile_done),
        .tile_psum    (tile_psum),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [64*DW-1:0] exp_q[$];

    // Tile engine knobs, written only by the test sequence.
    int eng_mode  = 0;
    int eng_delay = 0;
    bit eng_en    = 1'b1;
    int force_req = 0;

    // Tile engine state, written only by the engine process.
    bit         eng_busy  = 1'b0;
    int         eng_wait  = 0;
    logic [1:0] eng_r     = 2'd0;
    logic [1:0] eng_k     = 2'd0;
    int         force_ack = 0;
    int         ts_count  = 0;
    int         ord [0:1023];

    function automatic logic [DW-1:0] lane_val(int mode, int r, int k, int i);
        case (mode)
            0:       return DW'(1);
            1:       return DW'(r + 1);
            default: return (r == 0 && k == 0 && i == 0) ? DW'(16'hFFFF) : DW'(16'h4000);
        endcase
    endfunction

    function automatic logic [64*DW-1:0] exp_result(int mode);
        logic [64*DW-1:0] res;
        logic [DW-1:0]    s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                s = '0;
                for (int k = 0; k < 4; k++) s = s + lane_val(mode, r, k, i);
                res[(3 - r)*16*DW + i*DW +: DW] = s;
            end
        end
        return res;
    endfunction

    function automatic int first_diff(logic [64*DW-1:0] a, logic [64*DW-1:0] b);
        for (int i = 0; i < 64; i++) begin
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        end
        return -1;
    endfunction

    // Engine answers eng_delay cycles after the first WAIT cycle of each tile.
    always @(negedge clk) begin
        tile_done = 1'b0;
        if (force_req != force_ack) begin
            force_ack = force_req;
            tile_done = 1'b1;
            tile_psum = {16{DW'(7)}};
        end
        if (eng_busy) begin
            if (eng_wait == 0) begin
                tile_done = 1'b1;
                for (int i = 0; i < 16; i++)
                    tile_psum[i*DW +: DW] = lane_val(eng_mode, int'(eng_r), int'(eng_k), i);
                eng_busy = 1'b0;
            end else begin
                eng_wait = eng_wait - 1;
            end
        end
        if (tile_start === 1'b1) begin
            ord[ts_count & 1023] = int'(tile_row) * 4 + int'(tile_col);
            ts_count = ts_count + 1;
            if (eng_en) begin
                eng_busy = 1'b1;
                eng_wait = eng_delay;
                eng_r    = tile_row;
                eng_k    = tile_col;
            end
        end
    end

    task automatic apply_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            if (result_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, tile_start, tile_row, tile_col, result_valid, err} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {busy, tile_start, tile_row, tile_col, result_valid, err});
        end
        n_tests++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result lane %0d nonzero", first_diff(result, '0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int t0;
        bit saw_rv;
        eng_en = 1'b0;
        t0 = ts_count;
        saw_rv = 1'b0;
        apply_start();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_busy got %b required 1", busy);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) saw_rv = 1'b1;
        end
        n_tests++;
        if ({err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_early err,busy got %b required 01", {err, busy});
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_abort err,busy got %b required 10", {err, busy});
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) saw_rv = 1'b1;
        end
        n_tests++;
        if (saw_rv || result !== '0 || ts_count - t0 != 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_quiet rv=%b tiles=%0d err=%b required rv=0 tiles=1 err=1 result=0",
                     saw_rv, ts_count - t0, err);
        end
        eng_en = 1'b1;
    endtask

    task automatic test_ones();
        int t0, cyc, bad;
        bit got;
        logic [64*DW-1:0] exp;
        eng_mode = 0;
        eng_delay = 0;
        t0 = ts_count;
        exp_q.push_back(exp_result(0));
        apply_start();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_err_clear got %b required 0", err);
        end
        wait_valid(cyc, got);
        n_tests++;
        if (!got || cyc != 33) begin
            n_fail++;
            $display("FAIL ones_latency got %0d (valid=%b) required 33", cyc, got);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp || result[DW-1:0] !== DW'(4)) begin
            n_fail++;
            $display("FAIL ones_result lane %0d got %h required %h", first_diff(result, exp),
                     result[DW-1:0], exp[DW-1:0]);
        end
        bad = 0;
        for (int n = 0; n < 16; n++) if (ord[(t0 + n) & 1023] != n) bad++;
        n_tests++;
        if (ts_count - t0 != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL ones_order tiles=%0d misordered=%0d required 16 and 0", ts_count - t0, bad);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({result_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL ones_pulse rv,busy got %b required 00", {result_valid, busy});
        end
    endtask

    task automatic test_rowval();
        int cyc;
        bit got;
        logic [64*DW-1:0] exp;
        eng_mode = 1;
        eng_delay = 0;
        exp_q.push_back(exp_result(1));
        apply_start();
        wait_valid(cyc, got);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || result !== exp) begin
            n_fail++;
            $display("FAIL rowval_result valid=%b lane %0d differs", got, first_diff(result, exp));
        end
        n_tests++;
        if (result[1023:1008] !== 16'd4 || result[767:752] !== 16'd8 ||
            result[511:496] !== 16'd12 || result[255:240] !== 16'd16) begin
            n_fail++;
            $display("FAIL rowval_segments got %0d %0d %0d %0d required 4 8 12 16",
                     result[1023:1008], result[767:752], result[511:496], result[255:240]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit got;
        logic [64*DW-1:0] exp;
        logic [64*DW-1:0] top_only;
        eng_mode = 2;
        eng_delay = 0;
        exp_q.push_back(exp_result(2));
        apply_start();
        wait_valid(cyc, got);
        exp = exp_q.pop_front();
        top_only = '0;
        top_only[768 +: DW] = DW'(16'hBFFF);
        n_tests++;
        if (!got || result[768 +: DW] !== 16'hBFFF) begin
            n_fail++;
            $display("FAIL wrap_lane0 got %h required bfff", result[768 +: DW]);
        end
        n_tests++;
        if (result !== top_only || result !== exp) begin
            n_fail++;
            $display("FAIL wrap_carry lane %0d got %h required 0000", first_diff(result, top_only),
                     result[784 +: DW]);
        end
    endtask

    task automatic test_slow_boundary();
        int cyc;
        bit got;
        logic [64*DW-1:0] exp;
        eng_mode = 1;
        eng_delay = TO - 1;
        exp_q.push_back(exp_result(1));
        apply_start();
        wait_valid(cyc, got);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || err !== 1'b0 || cyc != 33 + 16 * (TO - 1)) begin
            n_fail++;
            $display("FAIL slow_latency valid=%b err=%b cycles %0d required %0d", got, err, cyc,
                     33 + 16 * (TO - 1));
        end
        n_tests++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL slow_result lane %0d differs", first_diff(result, exp));
        end
        eng_delay = 0;
    endtask

    task automatic test_busy_start();
        int t0, rv_cnt, t1;
        logic [64*DW-1:0] exp;
        logic [64*DW-1:0] held;
        eng_mode = 0;
        eng_delay = 1;
        t0 = ts_count;
        rv_cnt = 0;
        exp_q.push_back(exp_result(0));
        apply_start();
        for (int c = 1; c < 100; c++) begin
            start = (c == 5 || c == 20 || c == 40);
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) begin
                rv_cnt++;
                exp = exp_q.pop_front();
                n_tests++;
                if (result !== exp) begin
                    n_fail++;
                    $display("FAIL busy_result lane %0d differs", first_diff(result, exp));
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (rv_cnt != 1 || ts_count - t0 != 16) begin
            n_fail++;
            $display("FAIL busy_ignore valids=%0d tiles=%0d required 1 and 16", rv_cnt, ts_count - t0);
        end
        held = result;
        t1 = ts_count;
        force_req++;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) rv_cnt++;
        end
        n_tests++;
        if (rv_cnt != 1 || ts_count != t1 || busy !== 1'b0 || result !== held) begin
            n_fail++;
            $display("FAIL spurious_done valids=%0d new_tiles=%0d busy=%b required 1 0 0",
                     rv_cnt, ts_count - t1, busy);
        end
        eng_delay = 0;
    endtask

    task automatic test_rst_mid();
        int cyc, t0, guard;
        bit got, found;
        logic [64*DW-1:0] exp;
        eng_mode = 1;
        eng_delay = 0;
        found = 1'b0;
        guard = 0;
        exp_q.push_back(exp_result(1));
        apply_start();
        while (!found && guard < 100) begin
            @(negedge clk);
            guard++;
            if (tile_start === 1'b1 && tile_row == 2'd2 && tile_col == 2'd1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_reach tile (2,1) not issued within %0d cycles", guard);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({busy, tile_start, tile_row, tile_col, result_valid, err} !== 7'd0 || result !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got %b result_zero=%b required 0000000 1",
                     {busy, tile_start, tile_row, tile_col, result_valid, err}, result === '0);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        eng_mode = 2;
        eng_delay = 2;
        t0 = ts_count;
        exp_q.push_back(exp_result(2));
        apply_start();
        wait_valid(cyc, got);
        exp = exp_q.pop_front();
        n_tests++;
        if (!got || result !== exp || ord[t0 & 1023] != 0 || ts_count - t0 != 16) begin
            n_fail++;
            $display("FAIL rst_mid_restart valid=%b lane %0d first_tile=%0d tiles=%0d", got,
                     first_diff(result, exp), ord[t0 & 1023], ts_count - t0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_timeout();
        test_ones();
        test_rowval();
        test_wrap();
        test_slow_boundary();
        test_busy_start();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mvm64_tile_sched.md
MVM64_TILE_SCHED -- requirements
Module: mvm64_tile_sched

Interface
REQ-001 SHALL have parameter DW, default 16, width of one signed vector/psum lane.
REQ-002 SHALL have parameter TIMEOUT, default 1023, max WAIT cycles per tile before abort (range 1..65535).
REQ-003 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  request one 64x64 matrix-vector product; sampled in IDLE only.
REQ-006 SHALL have busy  output  1  high in every state except IDLE.
REQ-007 SHALL have tile_start  output  1  one-cycle pulse launching one 16x16 tile computation.
REQ-008 SHALL have tile_row  output  2  matrix block row r (output segment) of the current tile.
REQ-009 SHALL have tile_col  output  2  matrix block column k; also selects vector slice k.
REQ-010 SHALL have tile_done  input  1  tile engine completion pulse; tile_psum valid in the same cycle.
REQ-011 SHALL have tile_psum  input  16*DW  16-lane partial sum of the current tile.
REQ-012 SHALL have result  output  64*DW  full product; segment r at bits [(4-r)*16*DW-1 : (3-r)*16*DW].
REQ-013 SHALL have result_valid  output  1  one-cycle pulse when result is updated.
REQ-014 SHALL have err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: start=1 -> r=0, k=0, accumulator cleared, err cleared, next ISSUE; start=0 -> stay.
REQ-017 ISSUE: tile_start=1 for exactly one cycle with tile_row=r, tile_col=k; wait counter cleared; next WAIT.
REQ-018 WAIT: tile_done=1 -> each lane acc[i] = acc[i] + tile_psum[i], modulo 2^DW, no carry between lanes.
REQ-019 WAIT, tile_done=1, k<3 -> k=k+1, next ISSUE.
REQ-020 WAIT, tile_done=1, k=3 -> summed segment written to staging buffer slot r, acc cleared; r<3 -> r=r+1, k=0, ISSUE; r=3 -> DONE.
REQ-021 Tile order SHALL be (0,0),(0,1),(0,2),(0,3),(1,0) ... (3,3); 16 tiles per product.
REQ-022 WAIT, tile_done=0 -> wait counter +1; counter reaching TIMEOUT -> err=1, next IDLE, no result_valid, result unchanged.
REQ-023 tile_done in the same cycle the counter reaches TIMEOUT SHALL count as completion, no error.
REQ-024 DONE: result loaded from staging buffer in one cycle, result_valid=1 for that cycle, next IDLE.
REQ-025 result SHALL hold its value between result_valid pulses; partial products never visible on result.
REQ-026 tile_done in IDLE, ISSUE or DONE SHALL be ignored.
REQ-027 start while busy SHALL be ignored, not queued.
REQ-028 tile_row/tile_col SHALL hold stable from ISSUE through the end of WAIT.
REQ-029 Minimum latency, tile_done in the first WAIT cycle of each tile: result_valid 33 cycles after the edge sampling start.
REQ-030 Arithmetic SHALL be two's-complement; overflow wraps silently per lane.

Reset
REQ-031 rst=1 SHALL force IDLE, r=k=0, acc, staging buffer, wait counter and result to 0.
REQ-032 Reset values: busy=0, tile_start=0, tile_row=0, tile_col=0, result=0, result_valid=0, err=0.
REQ-033 rst during any state SHALL abort the product; the next start SHALL begin at tile (0,0) with a cleared accumulator.
REQ-034 rst SHALL take priority over start and tile_done in the same cycle.

Verification
REQ-035 Tile model answers in the first WAIT cycle with all lanes 1 -> every result lane = 4; result_valid 33 cycles after start; tile_start order (0,0)..(3,3).
REQ-036 Tile (r,k) returns all lanes = r+1 -> result[1023:768] lanes 4, [767:512] 8, [511:256] 12, [255:0] 16 (DW=16).
REQ-037 Every tile returns lanes 0x4000, lane 0 of tile (0,0) 0xFFFF -> segment 0 lane 0 = 0xBFFF, other lanes 0x0000, no cross-lane carry.
REQ-038 TIMEOUT=8, tile_done never asserted -> err=1 after 8 WAIT cycles of tile (0,0), busy=0, result_valid never pulses, result stays 0.
REQ-039 rst during WAIT of tile (2,1) -> all outputs 0 next cycle; a new start produces a correct full result from (0,0).
REQ-040 start pulsed while busy and spurious tile_done in IDLE -> no extra tile_start, result unchanged, one result_valid per accepted start.
